// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state type and parameter defaults for the fetch controller.
// Contents:
//   state_e      - controller state (BOOT bubble, RUN fetching, HALT idle)
//   ABITS_DEF    - default PC / instruction word width
//   RESET_PC_DEF - default word address fetched first after reset
package fetch_pkg;
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;
    localparam int ABITS_DEF = 32;
    localparam logic [ABITS_DEF-1:0] RESET_PC_DEF = '0;
endpackage

// File: rtl/pc_next.sv
// pc_next: combinational next-PC mux with pending-redirect bookkeeping.
// Ports:
//   run            - controller is in RUN; PC is frozen otherwise
//   halt, stall    - halt request / downstream back-pressure
//   redirect_valid - taken branch/jump, target on redirect_pc
//   pc, pend_flag, pend_pc - current registered state
//   pc_d, pend_flag_d, pend_pc_d - next-state values
//   moved          - PC advances (redirect, pending target or +1) this cycle
module pc_next import fetch_pkg::*; #(
    parameter int ABITS = ABITS_DEF
) (
    input  logic             run,
    input  logic             halt,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [ABITS-1:0] redirect_pc,
    input  logic [ABITS-1:0] pc,
    input  logic             pend_flag,
    input  logic [ABITS-1:0] pend_pc,
    output logic [ABITS-1:0] pc_d,
    output logic             pend_flag_d,
    output logic [ABITS-1:0] pend_pc_d,
    output logic             moved
);
    logic take, redir_now, redir_hold, pend_now, step;

    always_comb begin
        take        = run && !halt;
        redir_now   = take && redirect_valid && !stall;
        redir_hold  = take && redirect_valid && stall;
        pend_now    = take && !redirect_valid && !stall && pend_flag;
        step        = take && !redirect_valid && !stall && !pend_flag;
        pc_d        = redir_now ? redirect_pc : pend_now ? pend_pc : step ? pc + 1'b1 : pc;
        // A redirect taken while stalled parks its target; a later one overwrites it,
        // and an unstalled redirect supersedes whatever was parked.
        pend_flag_d = redir_hold || (pend_flag && !redir_now && !pend_now);
        pend_pc_d   = redir_hold ? redirect_pc : pend_pc;
        moved       = redir_now || pend_now || step;
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC sequencer and instruction fetch controller for the stack CPU.
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   stall                     - decode/execute cannot accept an instruction
//   redirect_valid/_pc        - taken branch/jump and its word-address target
//   halt, resume              - enter / leave the HALT state
//   imem_en, imem_pc          - instruction memory enable and word address
//   imem_dout                 - instruction word (combinational read)
//   inst, inst_valid, pc_out  - instruction, valid flag and its PC to decode
//   halted                    - controller is in HALT
//   perf_fetch, perf_redirect - saturating counters, present only with FETCH_PERF_EN
module fetch_ctrl import fetch_pkg::*; #(
    parameter int               ABITS    = ABITS_DEF,
    parameter logic [ABITS-1:0] RESET_PC = RESET_PC_DEF[ABITS-1:0]
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [ABITS-1:0] redirect_pc,
    input  logic             halt,
    input  logic             resume,
    output logic             imem_en,
    output logic [ABITS-1:0] imem_pc,
    input  logic [ABITS-1:0] imem_dout,
    output logic [ABITS-1:0] inst,
    output logic             inst_valid,
    output logic [ABITS-1:0] pc_out,
    output logic             halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      perf_fetch,
    output logic [31:0]      perf_redirect
`endif
);
    state_e           state_q, state_d;
    logic [ABITS-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d;
    logic             pend_flag_q, pend_flag_d, bubble_q, bubble_d;
    logic             run, moved;

    assign run = state_q == RUN;

    pc_next #(.ABITS(ABITS)) u_pc_next (
        .run            (run),
        .halt           (halt),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc_q),
        .pend_flag      (pend_flag_q),
        .pend_pc        (pend_pc_q),
        .pc_d           (pc_d),
        .pend_flag_d    (pend_flag_d),
        .pend_pc_d      (pend_pc_d),
        .moved          (moved)
    );

    always_comb begin
        state_d  = state_q == BOOT ? RUN :
                   (run && halt) ? HALT :
                   (state_q == HALT && resume) ? RUN : state_q;
        // The halting instruction already retired at the held PC, so the first RUN
        // cycle after resume is a bubble that lasts until the PC actually moves.
        bubble_d = (state_q == HALT && resume) || (bubble_q && !moved);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            pend_flag_q <= 1'b0;
            pend_pc_q   <= '0;
            bubble_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_flag_q <= pend_flag_d;
            pend_pc_q   <= pend_pc_d;
            bubble_q    <= bubble_d;
        end
    end

    assign imem_en    = run;
    assign imem_pc    = pc_q;
    assign inst       = run ? imem_dout : '0;
    assign inst_valid = run && !pend_flag_q && !bubble_q;
    assign pc_out     = pc_q;
    assign halted     = state_q == HALT;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_q, fetch_d, redir_q, redir_d;
    logic        applied;

    always_comb begin
        // A parked redirect counts once, when its target is finally loaded.
        applied = run && !halt && !stall && (redirect_valid || pend_flag_q);
        fetch_d = (inst_valid && !stall && fetch_q != '1) ? fetch_q + 32'd1 : fetch_q;
        redir_d = (applied && redir_q != '1) ? redir_q + 32'd1 : redir_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_q <= '0;
            redir_q <= '0;
        end else begin
            fetch_q <= fetch_d;
            redir_q <= redir_d;
        end
    end

    assign perf_fetch    = fetch_q;
    assign perf_redirect = redir_q;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table, wrap-around instance and randomized model check for fetch_ctrl.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset, stall, redirect_valid, halt, resume;
    logic [31:0] redirect_pc;
    logic        imem_en, inst_valid, halted;
    logic [31:0] imem_pc, imem_dout, inst, pc_out;
    logic        imem_en4, inst_valid4, halted4;
    logic [3:0]  imem_pc4, imem_dout4, inst4, pc_out4;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    assign imem_dout  = mem_word(imem_pc);
    assign imem_dout4 = ~imem_pc4;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch, perf_redirect, perf_fetch4, perf_redirect4;
`endif

    fetch_ctrl #(.ABITS(32), .RESET_PC(32'd0)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .resume(resume), .imem_en(imem_en),
        .imem_pc(imem_pc), .imem_dout(imem_dout), .inst(inst), .inst_valid(inst_valid),
        .pc_out(pc_out), .halted(halted)
`ifdef FETCH_PERF_EN
        , .perf_fetch(perf_fetch), .perf_redirect(perf_redirect)
`endif
    );

    fetch_ctrl #(.ABITS(4), .RESET_PC(4'd14)) u_dut4 (
        .clk(clk), .reset(reset), .stall(1'b0), .redirect_valid(1'b0),
        .redirect_pc(4'd0), .halt(1'b0), .resume(1'b0), .imem_en(imem_en4),
        .imem_pc(imem_pc4), .imem_dout(imem_dout4), .inst(inst4), .inst_valid(inst_valid4),
        .pc_out(pc_out4), .halted(halted4)
`ifdef FETCH_PERF_EN
        , .perf_fetch(perf_fetch4), .perf_redirect(perf_redirect4)
`endif
    );

    // Reference model: described by the controller's observable rules, not its registers.
    bit          m_boot, m_halt, m_skip;
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    longint      m_fetch, m_redir;

    function automatic bit m_running();
        return !m_boot && !m_halt;
    endfunction

    function automatic bit m_valid();
        return m_running() && m_pend.size() == 0 && !m_skip;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic model_chk();
        chk("valid", 32'(inst_valid), 32'(m_valid()));
        chk("pc", pc_out, m_pc);
        chk("imem_pc", imem_pc, m_pc);
        chk("imem_en", 32'(imem_en), 32'(m_running()));
        chk("inst", inst, m_running() ? mem_word(m_pc) : 32'd0);
        chk("halted", 32'(halted), 32'(m_halt));
`ifdef FETCH_PERF_EN
        chk("perf_fetch", perf_fetch, 32'(m_fetch));
        chk("perf_redirect", perf_redirect, 32'(m_redir));
`endif
    endtask

    task automatic model_step();
        bit v;
        v = m_valid();
        if (reset) begin
            m_boot = 1; m_halt = 0; m_skip = 0; m_pc = 32'd0;
            m_pend.delete(); m_fetch = 0; m_redir = 0;
        end else begin
            if (v && !stall && m_fetch < 64'hFFFF_FFFF) m_fetch++;
            if (m_boot) m_boot = 0;
            else if (m_halt) begin
                if (resume) begin m_halt = 0; m_skip = 1; end
            end
            else if (halt) m_halt = 1;
            else if (redirect_valid && !stall) begin
                m_pc = redirect_pc; m_pend.delete(); m_skip = 0;
                if (m_redir < 64'hFFFF_FFFF) m_redir++;
            end
            else if (redirect_valid) begin
                m_pend.delete(); m_pend.push_back(redirect_pc);
            end
            else if (stall) ;
            else if (m_pend.size() != 0) begin
                m_pc = m_pend.pop_front(); m_skip = 0;
                if (m_redir < 64'hFFFF_FFFF) m_redir++;
            end
            else begin m_pc = m_pc + 32'd1; m_skip = 0; end
        end
    endtask

    task automatic sample(input bit en);
        @(negedge clk);
        if (en) model_chk();
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        bit          rst, stl, rv;
        logic [31:0] rpc;
        bit          hlt, res;
        bit          ev;
        logic [31:0] epc;
        bit          een, ehl;
    } vec_t;

    vec_t vt[25];
    logic [3:0] w4[4];

    initial begin
        //         rst stl rv  rpc    hlt res  ev  epc   een ehl
        vt[0]  = '{0, 0, 0, 32'h00, 0, 0, 0, 32'h00, 0, 0};
        vt[1]  = '{0, 0, 0, 32'h00, 0, 0, 1, 32'h00, 1, 0};
        vt[2]  = '{0, 0, 0, 32'h00, 0, 0, 1, 32'h01, 1, 0};
        vt[3]  = '{0, 0, 0, 32'h00, 0, 0, 1, 32'h02, 1, 0};
        vt[4]  = '{0, 0, 0, 32'h00, 0, 0, 1, 32'h03, 1, 0};
        vt[5]  = '{0, 0, 1, 32'h20, 0, 0, 1, 32'h04, 1, 0};
        vt[6]  = '{0, 0, 1, 32'h07, 0, 0, 1, 32'h20, 1, 0};
        vt[7]  = '{0, 1, 0, 32'h00, 0, 0, 1, 32'h07, 1, 0};
        vt[8]  = '{0, 1, 1, 32'h40, 0, 0, 1, 32'h07, 1, 0};
        vt[9]  = '{0, 1, 0, 32'h00, 0, 0, 0, 32'h07, 1, 0};
        vt[10] = '{0, 0, 0, 32'h00, 0, 0, 0, 32'h07, 1, 0};
        vt[11] = '{0, 0, 1, 32'h09, 0, 0, 1, 32'h40, 1, 0};
        vt[12] = '{0, 0, 0, 32'h00, 1, 0, 1, 32'h09, 1, 0};
        vt[13] = '{0, 0, 0, 32'h00, 0, 0, 0, 32'h09, 0, 1};
        vt[14] = '{0, 0, 0, 32'h00, 1, 0, 0, 32'h09, 0, 1};
        vt[15] = '{0, 1, 1, 32'h77, 0, 0, 0, 32'h09, 0, 1};
        vt[16] = '{0, 0, 0, 32'h00, 0, 0, 0, 32'h09, 0, 1};
        vt[17] = '{0, 0, 0, 32'h00, 0, 1, 0, 32'h09, 0, 1};
        vt[18] = '{0, 0, 0, 32'h00, 0, 0, 0, 32'h09, 1, 0};
        vt[19] = '{0, 0, 0, 32'h00, 0, 1, 1, 32'h0A, 1, 0};
        vt[20] = '{0, 1, 1, 32'h50, 0, 0, 1, 32'h0B, 1, 0};
        vt[21] = '{1, 1, 0, 32'h00, 0, 0, 0, 32'h0B, 1, 0};
        vt[22] = '{0, 0, 0, 32'h00, 0, 0, 0, 32'h00, 0, 0};
        vt[23] = '{0, 0, 0, 32'h00, 0, 0, 1, 32'h00, 1, 0};
        vt[24] = '{0, 0, 0, 32'h00, 0, 0, 1, 32'h01, 1, 0};
        w4 = '{4'd14, 4'd14, 4'd15, 4'd0};

        reset = 1; stall = 0; redirect_valid = 0; redirect_pc = '0; halt = 0; resume = 0;
        for (int i = 0; i < 2; i++) begin
            sample(0);
            advance();
        end

        for (int i = 0; i < 25; i++) begin
            reset = vt[i].rst; stall = vt[i].stl; redirect_valid = vt[i].rv;
            redirect_pc = vt[i].rpc; halt = vt[i].hlt; resume = vt[i].res;
            sample(1);
            chk($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vt[i].ev));
            chk($sformatf("vec%0d_pc", i), pc_out, vt[i].epc);
            chk($sformatf("vec%0d_en", i), 32'(imem_en), 32'(vt[i].een));
            chk($sformatf("vec%0d_halted", i), 32'(halted), 32'(vt[i].ehl));
            chk($sformatf("vec%0d_inst", i), inst, vt[i].een ? mem_word(vt[i].epc) : 32'd0);
`ifdef FETCH_PERF_EN
            if (i == 22) begin
                chk("perf_fetch_after_reset", perf_fetch, 32'd0);
                chk("perf_redirect_after_reset", perf_redirect, 32'd0);
            end
`endif
            if (i < 4) begin
                chk($sformatf("wrap%0d_pc", i), 32'(pc_out4), 32'(w4[i]));
                chk($sformatf("wrap%0d_valid", i), 32'(inst_valid4), 32'(i != 0));
            end
            advance();
        end

        for (int i = 0; i < 3000; i++) begin
            reset          = $urandom_range(63) == 0;
            stall          = $urandom_range(2) == 0;
            redirect_valid = $urandom_range(4) == 0;
            redirect_pc    = $urandom_range(3) == 0 ? 32'hFFFF_FFFF - 32'($urandom_range(3)) : $urandom;
            halt           = $urandom_range(15) == 0;
            resume         = $urandom_range(3) == 0;
            sample(1);
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program-counter sequencer and fetch controller for the single-cycle stack CPU. It owns the PC register and drives the enable and word address of the instruction memory. It returns each fetched instruction with a valid flag and its PC to the decode stage. It handles stall, branch/jump redirect (including a redirect that arrives during a stall), and halt/resume.

## Interface
- ABITS, 32, width of PC and instruction word.
- RESET_PC, 0, word address fetched first after reset.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  decode/execute cannot accept an instruction this cycle.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  ABITS  target word address.
- halt  input  1  halt request (HALT opcode decoded).
- resume  input  1  leave halted state.
- imem_en  output  1  instruction memory enable.
- imem_pc  output  ABITS  instruction memory word address.
- imem_dout  input  ABITS  instruction word (combinational read).
- inst  output  ABITS  instruction to decode.
- inst_valid  output  1  inst is valid and will be consumed unless stall.
- pc_out  output  ABITS  PC of inst.
- halted  output  1  controller is in HALT.

## Operation
- The PC is a word address. Sequential fetch increments by 1, not 4. The PC wraps from 2^ABITS-1 to 0.
- FSM states:
  - BOOT: one bubble cycle after reset.
  - RUN: fetching.
  - HALT: idle.
- FSM transitions:
  - BOOT -> RUN unconditionally.
  - RUN -> HALT on halt.
  - HALT -> RUN on resume.
- imem_en = 1 only in RUN. imem_pc = pc. inst = imem_dout when imem_en is 1, otherwise 0. pc_out = pc.
- inst_valid = (state == RUN) and no pending redirect.
- PC update in RUN, in priority order:
  1. halt: pc holds, the halting instruction retires, enter HALT.
  2. redirect_valid with stall = 0: pc <= redirect_pc.
  3. redirect_valid with stall = 1: latch redirect_pc into pend_pc and set pend_flag. pc holds.
  4. stall: pc holds.
  5. Otherwise, if pend_flag is set: pc <= pend_pc and pend_flag clears.
  6. Otherwise: pc <= pc + 1.
- While pend_flag is set, inst_valid = 0. The old instruction must not be re-issued.
- A later redirect while pend_flag is set overwrites pend_pc (last writer wins).
- In HALT, stall, redirect and halt are ignored.
- On resume, pc is unchanged; fetch restarts at the instruction following the halt. The halting instruction's PC was held, so the first RUN cycle after resume advances pc by 1 before issuing (one bubble, inst_valid = 0).
- resume in a non-HALT state is ignored.

## Timing
- Reset values: state = BOOT, pc = RESET_PC, pend_flag = 0, pend_pc = 0, imem_en = 0, inst_valid = 0, inst = 0, halted = 0.
- Fetch latency is zero cycles: inst is a combinational function of pc in the same cycle. The PC changes only on the clock edge.
- First valid instruction: the second rising edge after reset deasserts (the BOOT bubble).
- Taken redirect: the target instruction is valid in the cycle after redirect_valid. No delay slot.
- Redirect during stall: the target is valid in the cycle after stall deasserts.
- halted rises in the cycle after halt is sampled. It falls in the cycle after resume is sampled.
- reset wins over every other input in any state and mid-stall, and clears any pending redirect.

## Configuration
- FETCH_PERF_EN defined:
  - Adds two 32-bit saturating counters: fetch_count (cycles with inst_valid = 1 and stall = 0) and redirect_count (applied redirects, counting a pending redirect once).
  - Adds outputs perf_fetch and perf_redirect, each 32 bits wide.
  - Both counters reset to 0.
- FETCH_PERF_EN undefined: counters and ports are absent. Functional behaviour is otherwise identical.

## Structure
- Shared package fetch_pkg holds:
  - the FSM state enum (BOOT, RUN, HALT);
  - the ABITS default;
  - the RESET_PC default.
- One sub-module, pc_next, is natural: a combinational next-PC mux implementing the priority list above.
- Instantiate inst_mem unchanged alongside this block at the CPU level. It is not inside fetch_ctrl.

## Test plan
- Reset with RESET_PC = 0, no stimulus for 5 cycles -> cycle 1 after reset has inst_valid = 0; cycles 2–5 give pc_out = 0, 1, 2, 3.
- At pc = 4, assert redirect_valid with redirect_pc = 0x20 -> next cycle pc_out = 0x20, inst_valid = 1.
- At pc = 7, hold stall for 3 cycles and assert a redirect to 0x40 in the second stall cycle, then release stall -> pc holds at 7 with inst_valid = 0 after the redirect; the cycle after stall drops shows pc_out = 0x40 and inst_valid = 1.
- At pc = 9, pulse halt, wait 4 cycles, then pulse resume -> halted = 1 and imem_en = 0 through the wait; after resume, one bubble, then pc_out = 0x0A.
- With ABITS = 4, run from pc = 14 -> sequence 14, 15, 0 (wrap-around).
- Assert reset mid-stall with pend_flag set -> pc returns to RESET_PC, pend_flag = 0, and the perf counters are 0 when FETCH_PERF_EN is defined.
